// File: rtl/vsync_pkg.sv
// Shared constants, lock-state encoding and helpers for the vsync conditioning path.
package vsync_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILT_LEN_DEF    = 4;
    localparam int unsigned PERIOD_W_DEF    = 24;
    localparam int unsigned LOCK_TOL_DEF    = 16;
    localparam int unsigned LOCK_COUNT_DEF  = 3;

    // Period differences are evaluated at this width; PERIOD_W must not exceed DIFF_W-1.
    localparam int unsigned DIFF_W = 33;

    typedef logic [1:0] lock_state_t;

    localparam lock_state_t StIdle   = 2'd0;
    localparam lock_state_t StMeas   = 2'd1;
    localparam lock_state_t StTrack  = 2'd2;
    localparam lock_state_t StLocked = 2'd3;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                  input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/vsync_sync_filter.sv
// Resynchronises the raw vsync pad and only follows a level held for FILT_LEN samples.
module vsync_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_raw,
    output logic vsync,
    output logic toggle
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       fcnt_q;
    logic [CNT_W-1:0]       fcnt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // toggle is high in the cycle before vsync flips, so edge logic can act on the same edge.
    always_comb begin
        fcnt_d = '0;
        toggle = 1'b0;
        if (s != vsync) begin
            if (fcnt_q == CNT_LAST) begin
                toggle = 1'b1;
            end else begin
                fcnt_d = fcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            fcnt_q <= '0;
            vsync  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vsync_raw};
            fcnt_q <= fcnt_d;
            vsync  <= vsync ^ toggle;
        end
    end

endmodule

// File: rtl/vsync_conditioner.sv
// Frame-sync conditioner: filtered vsync, edge pulses, frame-period measurement and lock.
module vsync_conditioner
    import vsync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
    parameter int unsigned LOCK_TOL    = LOCK_TOL_DEF,
    parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync_raw,
    output logic                vsync,
    output logic                vs_rise,
    output logic                vs_fall,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked
);

    localparam int unsigned MCNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MCNT_W-1:0]   MCNT_LOCK = MCNT_W'(LOCK_COUNT);
    localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;

    logic                vsync_toggle;
    logic                rise_evt;
    logic                fall_evt;
    logic [PERIOD_W-1:0] pcnt_q;
    logic [PERIOD_W-1:0] prev_q;
    logic [PERIOD_W-1:0] prev_d;
    logic [PERIOD_W-1:0] period_d;
    logic [PERIOD_W-1:0] m;
    logic                sat;
    logic                period_match;
    logic                pv_d;
    logic [MCNT_W-1:0]   mcnt_q;
    logic [MCNT_W-1:0]   mcnt_d;
    lock_state_t         state_q;
    lock_state_t         state_d;

    vsync_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sync_filter (
        .clk      (clk),
        .reset    (reset),
        .vsync_raw(vsync_raw),
        .vsync    (vsync),
        .toggle   (vsync_toggle)
    );

    assign rise_evt = vsync_toggle & ~vsync;
    assign fall_evt = vsync_toggle & vsync;

    assign sat          = (pcnt_q == PCNT_MAX);
    assign m            = sat ? PCNT_MAX : (pcnt_q + PERIOD_W'(1));
    assign period_match = !sat &&
        (abs_diff(DIFF_W'(m), DIFF_W'(prev_q)) <= DIFF_W'(LOCK_TOL));

    // While locked, prev holds the reference period so slow jitter cannot walk it away.
    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        prev_d   = prev_q;
        period_d = period;
        pv_d     = 1'b0;
        if (sat && (state_q != StIdle)) begin
            state_d = StIdle;
            mcnt_d  = '0;
        end else if (rise_evt) begin
            unique case (state_q)
                StIdle: state_d = StMeas;
                StMeas: begin
                    period_d = m;
                    pv_d     = 1'b1;
                    prev_d   = m;
                    mcnt_d   = '0;
                    state_d  = StTrack;
                end
                StTrack: begin
                    period_d = m;
                    pv_d     = 1'b1;
                    prev_d   = m;
                    if (period_match) begin
                        mcnt_d = mcnt_q + MCNT_W'(1);
                        if (mcnt_d == MCNT_LOCK) state_d = StLocked;
                    end else begin
                        mcnt_d = '0;
                    end
                end
                StLocked: begin
                    period_d = m;
                    pv_d     = 1'b1;
                    if (!period_match) begin
                        prev_d  = m;
                        mcnt_d  = '0;
                        state_d = StTrack;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q       <= '0;
            prev_q       <= '0;
            mcnt_q       <= '0;
            state_q      <= StIdle;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            vs_rise      <= 1'b0;
            vs_fall      <= 1'b0;
        end else begin
            if (rise_evt) begin
                pcnt_q <= '0;
            end else if (!sat) begin
                pcnt_q <= pcnt_q + PERIOD_W'(1);
            end
            prev_q       <= prev_d;
            mcnt_q       <= mcnt_d;
            state_q      <= state_d;
            period       <= period_d;
            period_valid <= pv_d;
            locked       <= (state_d == StLocked);
            vs_rise      <= rise_evt;
            vs_fall      <= fall_evt;
        end
    end

endmodule

// File: tb/tb_vsync_conditioner.sv
// Bench for vsync_conditioner: hand sequences for filtering/reset, table of frames for lock.
module tb_vsync_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        raw;
    logic        raw2;
    logic        vsync, vs_rise, vs_fall, period_valid, locked;
    logic [23:0] period;
    logic        vsync2, vs_rise2, vs_fall2, period_valid2, locked2;
    logic [9:0]  period2;

    always #5 clk = ~clk;

    vsync_conditioner dut (
        .clk         (clk),
        .reset       (reset),
        .vsync_raw   (raw),
        .vsync       (vsync),
        .vs_rise     (vs_rise),
        .vs_fall     (vs_fall),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked)
    );

    vsync_conditioner #(.PERIOD_W(10)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .vsync_raw   (raw2),
        .vsync       (vsync2),
        .vs_rise     (vs_rise2),
        .vs_fall     (vs_fall2),
        .period      (period2),
        .period_valid(period_valid2),
        .locked      (locked2)
    );

    typedef struct {
        int unsigned len;  // cycles from this raw rise to the next one
        bit          pv;   // period_valid expected on this rise
        int unsigned per;  // period expected on this rise
        bit          lk;   // locked expected right after this rise
    } vec_t;

    typedef struct {
        bit          pv;
        int unsigned per;
        bit          lk;
    } exp_t;

    exp_t sb[$];
    bit   sb_on = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_rise = 0;
    int   n_fall = 0;
    int   n_high = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run2(input int n, output int pv);
        pv = 0;
        repeat (n) begin
            step(1);
            if (period_valid2) pv++;
        end
    endtask

    always @(negedge clk) begin
        if (vs_rise) n_rise++;
        if (vs_fall) n_fall++;
        if (vsync) n_high++;
    end

    // Scoreboard: one expectation is queued per raw rise and consumed at the vs_rise it causes.
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && vs_rise) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rise", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_period_valid", period_valid, e.pv);
                check("sb_locked", locked, e.lk);
                if (e.pv) check("sb_period", period, e.per);
            end
        end
        if (sb_on && period_valid && !vs_rise) check("sb_stray_period_valid", 1, 0);
    end

    initial begin
        vec_t tbl[11];
        int   rb, fb, hb, idx, drop, pv;
        bit   pv_seen;

        tbl[0]  = '{1000, 0, 0,    0};
        tbl[1]  = '{1000, 1, 1000, 0};
        tbl[2]  = '{1000, 1, 1000, 0};
        tbl[3]  = '{1000, 1, 1000, 0};
        tbl[4]  = '{1010, 1, 1000, 1};
        tbl[5]  = '{990,  1, 1010, 1};
        tbl[6]  = '{1040, 1, 990,  1};
        tbl[7]  = '{1040, 1, 1040, 0};
        tbl[8]  = '{1040, 1, 1040, 0};
        tbl[9]  = '{1040, 1, 1040, 0};
        tbl[10] = '{1040, 1, 1040, 1};

        reset = 1'b1;
        raw   = 1'b0;
        raw2  = 1'b0;
        step(3);
        check("rst_vsync", vsync, 0);
        check("rst_vs_rise", vs_rise, 0);
        check("rst_vs_fall", vs_fall, 0);
        check("rst_period", period, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;

        // Clean 50-cycle pulse: both edges appear 6 cycles after the raw edge.
        step(1);
        raw = 1'b1;
        step(5);
        check("clean_vsync_before", vsync, 0);
        step(1);
        check("clean_vsync_rise", vsync, 1);
        check("clean_vs_rise", vs_rise, 1);
        step(1);
        check("clean_vs_rise_1cyc", vs_rise, 0);
        step(43);
        raw = 1'b0;
        step(5);
        check("clean_vsync_hold", vsync, 1);
        check("clean_vs_fall_early", vs_fall, 0);
        step(1);
        check("clean_vsync_fall", vsync, 0);
        check("clean_vs_fall", vs_fall, 1);
        step(1);
        check("clean_vs_fall_1cyc", vs_fall, 0);

        // Glitches of 1..3 cycles are swallowed; 4 cycles passes exactly once.
        step(10);
        rb = n_rise;
        fb = n_fall;
        hb = n_high;
        for (int w = 1; w <= 3; w++) begin
            raw = 1'b1;
            step(w);
            raw = 1'b0;
            step(12);
        end
        step(10);
        check("glitch_rise", n_rise - rb, 0);
        check("glitch_fall", n_fall - fb, 0);
        check("glitch_high", n_high - hb, 0);
        raw = 1'b1;
        step(4);
        raw = 1'b0;
        step(20);
        check("pulse4_rise", n_rise - rb, 1);
        check("pulse4_fall", n_fall - fb, 1);

        // Frame table: acquisition, jitter within tolerance, a miss and relock.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        sb_on = 1'b1;
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].pv, tbl[i].per, tbl[i].lk});
            raw = 1'b1;
            step(50);
            raw = 1'b0;
            step(int'(tbl[i].len) - 50);
        end

        // Reset for one cycle in the middle of a locked pulse.
        sb.push_back('{1, 1040, 1});
        raw = 1'b1;
        step(20);
        check("mid_locked_before", locked, 1);
        check("mid_vsync_before", vsync, 1);
        reset = 1'b1;
        step(1);
        check("mid_rst_vsync", vsync, 0);
        check("mid_rst_vs_rise", vs_rise, 0);
        check("mid_rst_vs_fall", vs_fall, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_period_valid", period_valid, 0);
        check("mid_rst_locked", locked, 0);
        fb = n_fall;
        reset = 1'b0;
        sb.push_back('{0, 0, 0});
        step(15);
        check("mid_no_spurious_fall", n_fall - fb, 0);
        check("mid_vsync_reacquired", vsync, 1);
        raw = 1'b0;
        step(20);
        check("sb_drained", sb.size(), 0);
        sb_on = 1'b0;

        // Loss of sync on the 10-bit instance.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            raw2 = 1'b1;
            step(50);
            raw2 = 1'b0;
            step(50);
        end
        check("los_locked", locked2, 1);
        check("los_period", period2, 100);
        // Last raw rise was 100 edges ago; vsync rose on edge 6, saturation at pcnt 1023.
        idx     = 100;
        drop    = -1;
        pv_seen = 1'b0;
        for (int k = 0; k < 1200 && drop < 0; k++) begin
            step(1);
            idx++;
            if (period_valid2) pv_seen = 1'b1;
            if (!locked2) drop = idx;
        end
        check("los_drop_not_early", (drop >= 1029) ? 1 : 0, 1);
        check("los_drop_not_late", (drop >= 0 && drop <= 1031) ? 1 : 0, 1);
        check("los_no_period_valid", pv_seen, 0);
        raw2 = 1'b1;
        run2(50, pv);
        raw2 = 1'b0;
        check("los_arm_no_pv", pv, 0);
        check("los_arm_unlocked", locked2, 0);
        run2(50, pv);
        raw2 = 1'b1;
        run2(10, pv);
        check("los_meas_pv", pv, 1);
        check("los_meas_period", period2, 100);
        raw2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
